// File: rtl/seq_decoder_pkg.sv
// Shared types and widths for the sequenced one-hot decoder.
package seq_decoder_pkg;
  localparam int CODE_W = 3;
  localparam int LINE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/seq_decoder_onehot_dec.sv
// Combinational 3-to-8 one-hot decoder feeding the seq_decoder output register.
module onehot_dec3to8
  import seq_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [LINE_W-1:0] line_o
);
  assign line_o = LINE_W'(1) << code_i;
endmodule

// File: rtl/seq_decoder.sv
// Accepts a 3-bit index, drives its one-hot line for HOLD_CYCLES, then idles GAP_CYCLES.
// Optional sticky accept history enabled by defining SEQ_DECODER_HIST_EN.
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [LINE_W-1:0] out,
  output logic              out_valid,
  output logic              busy
`ifdef SEQ_DECODER_HIST_EN
  ,
  input  logic              hist_clr,
  output logic [LINE_W-1:0] hist
`endif
);
  localparam int CW = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [LINE_W-1:0]   out_q, out_d;
  logic                rdy_q, busy_q, outv_q;
  logic                accept;
  logic [CODE_W-1:0]   dec_code;
  logic [LINE_W-1:0]   dec_line;

  assign accept   = in_valid & rdy_q;
  // Decoder sees the live code only on the accept cycle, the latched one otherwise.
  assign dec_code = accept ? in_code : code_q;

  onehot_dec3to8 u_dec (
    .code_i (dec_code),
    .line_o (dec_line)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    out_d   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRIVE;
          cnt_d   = CW'(HOLD_CYCLES);
          code_d  = in_code;
          out_d   = dec_line;
        end
      end
      DRIVE: begin
        if (cnt_q == CW'(1)) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYCLES);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          out_d = dec_line;
        end
      end
      GAP: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status flags are registered from next-state so every output comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      out_q   <= '0;
      outv_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      out_q   <= out_d;
      outv_q  <= |out_d;
      rdy_q   <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign out       = out_q;
  assign out_valid = outv_q;
  assign in_ready  = rdy_q;
  assign busy      = busy_q;

`ifdef SEQ_DECODER_HIST_EN
  logic [LINE_W-1:0] hist_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        hist_q <= '0;
    else if (accept)   hist_q <= hist_clr ? dec_line : (hist_q | dec_line);
    else if (hist_clr) hist_q <= '0;
  end
  assign hist = hist_q;
`endif
endmodule

// File: tb/tb_seq_decoder.sv
// Directed table plus hand sequences for seq_decoder (default and HOLD=1/GAP=0 builds).
module tb_seq_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = '0;
  logic       in_ready, out_valid, busy;
  logic [7:0] out;
  logic       vb = 1'b0;
  logic [2:0] cb = '0;
  logic       rdy_b, ov_b, busy_b;
  logic [7:0] out_b;
`ifdef SEQ_DECODER_HIST_EN
  logic       hist_clr = 1'b0;
  logic [7:0] hist, hist_b;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .busy(busy)
`ifdef SEQ_DECODER_HIST_EN
    , .hist_clr(hist_clr), .hist(hist)
`endif
  );

  seq_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_code(cb),
    .in_ready(rdy_b), .out(out_b), .out_valid(ov_b), .busy(busy_b)
`ifdef SEQ_DECODER_HIST_EN
    , .hist_clr(1'b0), .hist(hist_b)
`endif
  );

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic [7:0] eo;
    logic       er;
    logic       eb;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

`ifdef SEQ_DECODER_HIST_EN
  task automatic send(input logic [2:0] c, input logic clr);
    wait_ready();
    in_code = c; in_valid = 1'b1; hist_clr = clr;
    step();
    in_valid = 1'b0; hist_clr = 1'b0;
  endtask
`endif

  function automatic vec_t mk(input logic v, input logic [2:0] c, input logic [7:0] eo,
                              input logic er, input logic eb);
    vec_t r;
    r.v = v; r.c = c; r.eo = eo; r.er = er; r.eb = eb;
    return r;
  endfunction

  initial begin
    // single pulse of code 5, then code 2 with a mid-drive change to 4
    tbl[0]  = mk(1, 5, 8'h20, 0, 1);
    tbl[1]  = mk(0, 0, 8'h20, 0, 1);
    tbl[2]  = mk(0, 0, 8'h20, 0, 1);
    tbl[3]  = mk(0, 0, 8'h20, 0, 1);
    tbl[4]  = mk(0, 0, 8'h00, 0, 1);
    tbl[5]  = mk(0, 0, 8'h00, 1, 0);
    tbl[6]  = mk(1, 2, 8'h04, 0, 1);
    tbl[7]  = mk(1, 4, 8'h04, 0, 1);
    tbl[8]  = mk(1, 4, 8'h04, 0, 1);
    tbl[9]  = mk(1, 4, 8'h04, 0, 1);
    tbl[10] = mk(1, 4, 8'h00, 0, 1);
    tbl[11] = mk(1, 4, 8'h00, 1, 0);
    tbl[12] = mk(1, 4, 8'h10, 0, 1);
    tbl[13] = mk(0, 0, 8'h10, 0, 1);
    tbl[14] = mk(0, 0, 8'h10, 0, 1);
    tbl[15] = mk(0, 0, 8'h10, 0, 1);
    tbl[16] = mk(0, 0, 8'h00, 0, 1);
    tbl[17] = mk(0, 0, 8'h00, 1, 0);

    #12;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_oval", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("pre_edge_ready", 32'(in_ready), 32'd0);
    step();
    chk("first_edge_ready", 32'(in_ready), 32'd1);
    chk("first_edge_ready_b", 32'(rdy_b), 32'd1);

    for (int i = 0; i < 18; i++) begin
      in_valid = tbl[i].v;
      in_code  = tbl[i].c;
      step();
      chk($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_oval", i), 32'(out_valid), 32'(tbl[i].eo != 8'h00));
    end

    // sweep all codes with in_valid held high
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      wait_ready();
      in_code = 3'(c);
      for (int k = 0; k < 4; k++) begin
        step();
        chk($sformatf("sweep%0d_out%0d", c, k), 32'(out), 32'(8'h01 << c));
        chk($sformatf("sweep%0d_rdy%0d", c, k), 32'(in_ready), 32'd0);
      end
      step();
      chk($sformatf("sweep%0d_gap", c), 32'(out), 32'h0);
      chk($sformatf("sweep%0d_gaprdy", c), 32'(in_ready), 32'd0);
      step();
      chk($sformatf("sweep%0d_idle", c), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;

    // HOLD=1, GAP=0: codes 3 then 6 back to back
    vb = 1'b1; cb = 3'd3;
    step();
    chk("b_out08", 32'(out_b), 32'h08);
    cb = 3'd6;
    step();
    chk("b_out00", 32'(out_b), 32'h00);
    chk("b_rdy", 32'(rdy_b), 32'd1);
    step();
    chk("b_out40", 32'(out_b), 32'h40);
    chk("b_oval", 32'(ov_b), 32'd1);
    vb = 1'b0;
    step();
    chk("b_end_out", 32'(out_b), 32'h00);
    chk("b_end_rdy", 32'(rdy_b), 32'd1);

    // reset during the 2nd drive cycle of code 7
    wait_ready();
    in_code = 3'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("r_drive1", 32'(out), 32'h80);
    step();
    chk("r_drive2", 32'(out), 32'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("r_out", 32'(out), 32'h0);
    chk("r_oval", 32'(out_valid), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_ready", 32'(in_ready), 32'd0);
    step();
    chk("r_ready_hold", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("r_release_ready", 32'(in_ready), 32'd1);
    chk("r_release_out", 32'(out), 32'h0);
    step();
    chk("r_no_resume", 32'(out), 32'h0);
    chk("r_no_resume_busy", 32'(busy), 32'd0);

`ifdef SEQ_DECODER_HIST_EN
    hist_clr = 1'b1;
    step();
    hist_clr = 1'b0;
    chk("h_clear", 32'(hist), 32'h0);
    send(3'd1, 1'b0);
    send(3'd4, 1'b0);
    chk("h_12", 32'(hist), 32'h12);
    send(3'd0, 1'b1);
    chk("h_01", 32'(hist), 32'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, number of cycles a decoded line is driven; legal range 1..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 1, number of idle cycles after each drive; legal range 0..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  encoded index offered.
REQ-006 SHALL have port in_code  input  3  encoded index (0..7), same encoding as the team's 8-to-3 priority encoder output.
REQ-007 SHALL have port in_ready  output  1  block can accept an index this cycle.
REQ-008 SHALL have port out  output  8  registered one-hot decoded line.
REQ-009 SHALL have port out_valid  output  1  high exactly while out is non-zero.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement states IDLE, DRIVE and GAP; all outputs are driven from registers.
REQ-012 SHALL assert in_ready only in IDLE, and accept an index when in_valid and in_ready are both high at a clock edge.
REQ-013 SHALL, on accept, latch in_code, move to DRIVE, and drive out = 1 << code starting the cycle after accept, so latency is 1 cycle.
REQ-014 SHALL hold out constant for exactly HOLD_CYCLES cycles, independent of later in_code or in_valid changes.
REQ-015 SHALL, after DRIVE, go to GAP with out = 0 for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-016 SHALL, when GAP_CYCLES = 0, go from DRIVE directly to IDLE, so back-to-back drives are separated by one IDLE cycle (the accept cycle).
REQ-017 SHALL ignore in_valid in DRIVE and GAP; no request is queued or lost-flagged, and the sender must hold in_valid until accepted.
REQ-018 SHALL use one down-counter of width $clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1), loaded on each state entry; the state advances when the counter reaches 1.
REQ-019 SHALL treat every in_code value 0..7 as legal; no default or invalid case exists.

Reset
REQ-020 SHALL, while rst_n is low, asynchronously force state = IDLE, counter = 0, latched code = 0, out = 8'h00, out_valid = 0, busy = 0, in_ready = 0.
REQ-021 SHALL raise in_ready on the first clock edge after rst_n deasserts.
REQ-022 SHALL zero out immediately on reset assertion during DRIVE, and SHALL NOT resume the interrupted drive after reset.

Configuration
REQ-023 SHALL add ports hist_clr (input, 1) and hist (output, 8) when the macro SEQ_DECODER_HIST_EN is defined; the ports are absent otherwise.
REQ-024 SHALL, with SEQ_DECODER_HIST_EN defined, set hist[code] on each accept and keep it set (sticky) until hist_clr is high.
REQ-025 SHALL, with SEQ_DECODER_HIST_EN defined and hist_clr high in the same cycle as an accept, clear all hist bits except the newly accepted bit, which is set; hist resets to 8'h00.
REQ-026 SHALL, without the macro, contain no history logic and behave identically otherwise.

Structure
REQ-027 SHALL place state encoding (IDLE=2'd0, DRIVE=2'd1, GAP=2'd2) and CODE_W=3, LINE_W=8 in shared package seq_decoder_pkg.
REQ-028 SHALL instantiate one sub-module, onehot_dec3to8: a combinational 3-to-8 decoder feeding the out register.

Verification
REQ-029 SHALL verify that with default parameters, in_code=3'd5 and in_valid pulsed 1 cycle while idle produce out=8'h20 for 4 cycles starting the next cycle, then 1 cycle at 0, then in_ready=1.
REQ-030 SHALL verify that sweeping codes 0..7 with in_valid held high produces out sequence 01,02,04,...,80, each for HOLD_CYCLES cycles, with in_ready never high in DRIVE or GAP.
REQ-031 SHALL verify that with HOLD_CYCLES=1 and GAP_CYCLES=0, codes 3 then 6 give out=08 for 1 cycle, 00 for 1 cycle, then 40.
REQ-032 SHALL verify that rst_n dropped in the 2nd DRIVE cycle of code 7 forces out=00 the same cycle, in_ready=0 during reset, and in_ready=1 one edge after release.
REQ-033 SHALL verify that changing in_code from 2 to 4 during DRIVE keeps out=04 (code 2 held) and that code 4 is not accepted until IDLE.
REQ-034 SHALL verify, with SEQ_DECODER_HIST_EN defined, that accepting codes 1 and 4 gives hist=8'h12, and that hist_clr asserted with an accept of code 0 gives hist=8'h01.
